uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter between NUM_REQ requesters, for example a button-triggered message sender, a received-byte echo path and a status reporter.
- Arbitration is round-robin and packet-locked: once a requester is granted, its bytes go out back-to-back until it flags the last byte or the idle watchdog fires.
- Sits between the requester logic and the UART TX bit serializer, which consumes tx_data through a valid/ready handshake.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT, 16, cycles a granted requester may hold req_valid low mid-packet before its grant is revoked (>=2)
TO_W, 5, timeout counter width; must satisfy 2**TO_W > TIMEOUT

Ports:
saatDarbesi  in  1  system clock
sifirlama  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  marks the final byte of a packet; qualified by req_valid
req_ready  out  NUM_REQ  per-requester byte accept
tx_data  out  8  byte to the UART TX serializer
tx_valid  out  1  tx_data valid
tx_ready  in  1  serializer accepts tx_data
grant  out  NUM_REQ  one-hot current owner; 0 when idle
busy  out  1  high whenever state != IDLE
timeout_evt  out  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset (async, high). All of the following take effect immediately, regardless of clock:
  - tx_valid=0, tx_data=0x00, grant=0, busy=0, timeout_evt=0, req_ready=0.
  - Priority pointer=0, timeout counter=0, state=IDLE.
  - Any in-flight byte is discarded. No partial-packet recovery after reset.
- States: IDLE, XFER, DRAIN.
- IDLE:
  - If any req_valid is set, pick a winner by scanning from the pointer upward with wrap. Register grant=onehot(winner) and go to XFER.
  - req_ready=0 throughout IDLE.
  - Latency: req_valid in cycle 0 gives grant and req_ready in cycle 1, and tx_valid in cycle 2.
- XFER:
  - req_ready[g] = (!tx_valid || tx_ready). It is combinational and zero for non-granted requesters.
  - On req_valid[g] && req_ready[g]: tx_data<=req_data[g], tx_valid<=1 on the next edge.
  - If tx_ready is high and nothing new is accepted, tx_valid<=0.
  - tx_data is held stable while tx_valid && !tx_ready.
  - An accepted byte with req_last[g]=1 moves the block to DRAIN.
- Timeout counter:
  - Increments each XFER cycle with req_valid[g]=0.
  - Clears on any accepted byte and on XFER entry.
  - Cycles stalled by tx_ready=0 while req_valid[g]=1 do not count.
  - When the counter reaches TIMEOUT: timeout_evt=1 for one cycle, move to DRAIN.
- DRAIN:
  - req_ready=0.
  - Wait until !tx_valid, or tx_valid && tx_ready, so the final byte is delivered.
  - Then pointer <= (g+1) mod NUM_REQ, grant<=0, go to IDLE.
  - At least one IDLE cycle always separates packets.
- Simultaneous events:
  - Last-byte accept and timeout in the same cycle: the accept wins, and timeout_evt stays 0.
  - A non-granted requester's valid is ignored until the next arbitration.
  - A requester that drops valid while not granted loses nothing.
- The requester must hold req_data/req_last stable while req_valid && !req_ready. The bench asserts this; the RTL does not check it.
- Pointer arithmetic wraps at NUM_REQ, which need not be a power of two.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum {IDLE, XFER, DRAIN};
  - default NUM_REQ and TIMEOUT;
  - a clog2 helper for pointer width;
  - a byte typedef.
- Sub-module rr_pick: combinational round-robin picker with inputs req[NUM_REQ] and ptr, outputs onehot and index. It is instantiated once.

Test Plan:
1. Only req0 sends 0x4D, 0x65, 0x0A with last on 0x0A, tx_ready=1 throughout -> tx bytes 4D, 65, 0A in consecutive cycles starting 2 cycles after req_valid; grant=001; busy falls after DRAIN; pointer=1.
2. Right after reset, req0 and req2 each present a 2-byte packet (0x11,0x12 / 0x21,0x22) -> tx order 11, 12, 21, 22 with no interleave, and one IDLE cycle between the packets.
3. All three requesters continuously offer 1-byte packets -> grant sequence 001, 010, 100, 001, 010, 100; each requester gets exactly one byte per round.
4. Mid-packet tx_ready=0 for 50 cycles with TIMEOUT=16 and req_valid[g]=1 -> no timeout_evt; tx_data stays stable; no byte lost or duplicated.
5. req1 sends 0x31 without last, then req_valid[1]=0 -> timeout_evt pulses exactly 16 cycles later; 0x31 is delivered; grant clears; a pending req2 is served next.
6. sifirlama pulsed mid-packet, between clock edges -> all outputs reach reset values before the next edge; after release, a 1-byte packet 0x55 from req0 is transmitted normally.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

    localparam int DEFAULT_NUM_REQ = 3;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Width needed to hold an index in 0..n-1. Never returns less than 1,
    // so a two-requester build still gets a real pointer bit.
    function automatic int ptr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping at NUM_REQ (which need not be a power of two).
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   index,
    output logic               found
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_REQ);

    // cand_idx[k] is the requester k places after the pointer; cand_req is
    // the request vector rotated into that order.
    logic [PTR_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [PTR_W:0] sum;
            assign sum          = {1'b0, ptr} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum >= N_EXT) ? PTR_W'(sum - N_EXT) : sum[PTR_W-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end down so the candidate closest to the pointer wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                index = cand_idx[k];
                found = 1'b1;
            end
        end
        if (found) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between NUM_REQ requesters.
// Round-robin, packet-locked arbitration with an idle watchdog that revokes
// a grant when the owner stops offering bytes mid-packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = 5
) (
    input  logic                 saatDarbesi,
    input  logic                 sifirlama,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_evt
);

    localparam int               PTR_W     = ptr_width(NUM_REQ);
    localparam logic [TO_W-1:0]  TIMEOUT_C = TO_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [TO_W-1:0]    to_cnt_q;
    logic [TO_W-1:0]    to_cnt_d;
    byte_t              tx_data_q;
    logic               tx_valid_q;
    logic               timeout_evt_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;

    byte_t              masked_data [NUM_REQ];
    byte_t              g_data;
    logic               g_valid;
    logic               g_last;
    logic               slot_free;
    logic               accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .found  (pick_found)
    );

    // Only the granted requester's byte survives the mask.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_data[gi] = req_data[8*gi +: 8] & {8{grant_q[gi]}};
        end
    endgenerate

    // Collapse the owner's byte, valid and last flags out of the request bus.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            g_data = g_data | masked_data[i];
        end
    end

    assign g_valid   = |(req_valid & grant_q);
    assign g_last    = |(req_last & grant_q);
    // The output register can take a byte when empty or emptying this cycle.
    assign slot_free = !tx_valid_q || tx_ready;
    assign accept    = (state_q == XFER) && g_valid && slot_free;
    assign req_ready = ((state_q == XFER) && slot_free) ? grant_q : '0;

    assign to_cnt_d  = to_cnt_q + 1'b1;
    assign ptr_d     = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_evt = timeout_evt_q;

    // Arbitration FSM with the output byte register and idle watchdog.
    always_ff @(posedge saatDarbesi or posedge sifirlama) begin
        if (sifirlama) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            ptr_q         <= '0;
            to_cnt_q      <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            timeout_evt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_valid_q <= 1'b0;
                    if (pick_found) begin
                        grant_q  <= pick_onehot;
                        gidx_q   <= pick_idx;
                        to_cnt_q <= '0;
                        state_q  <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        tx_data_q  <= g_data;
                        tx_valid_q <= 1'b1;
                        to_cnt_q   <= '0;
                        if (g_last) begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        if (tx_ready) begin
                            tx_valid_q <= 1'b0;
                        end
                        // Only an owner that has gone quiet counts toward the
                        // watchdog; back-pressure stalls leave it untouched.
                        if (!g_valid) begin
                            to_cnt_q <= to_cnt_d;
                            if (to_cnt_d == TIMEOUT_C) begin
                                timeout_evt_q <= 1'b1;
                                state_q       <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Hold the grant until the last byte has left the register.
                    if (slot_free) begin
                        tx_valid_q <= 1'b0;
                        grant_q    <= '0;
                        ptr_q      <= ptr_d;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requesters are fed from per-requester
// byte lists, expected grants and bytes go into queues, and a monitor on the
// falling edge pops and compares whenever the DUT shows a grant or a byte.
module tb_uart_tx_arbiter;

    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            timeout_evt;

    uart_tx_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (16),
        .TO_W    (5)
    ) dut (
        .saatDarbesi (clk),
        .sifirlama   (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus lists: {last, data} per entry, consumed on each accepted byte.
    logic [8:0]  stim_mem [NR][64];
    int          head [NR];
    int          tail [NR];

    logic [10:0] exp_tx_q [$];     // {grant, byte}
    logic [2:0]  exp_grant_q [$];
    int          hs_cyc_q [$];

    int checks    = 0;
    int errors    = 0;
    int hs_count  = 0;
    int to_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        stim_mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic expect_tx(input logic [2:0] g, input logic [7:0] d);
        exp_tx_q.push_back({g, d});
    endtask

    task automatic expect_grant(input logic [2:0] g);
        exp_grant_q.push_back(g);
    endtask

    // Requester model: present the head entry, advance after a handshake.
    initial begin : driver
        logic [NR-1:0] acc;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = stim_mem[i][head[i]][7:0];
                    req_last[i]         = stim_mem[i][head[i]][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        logic [2:0]      prev_grant;
        logic [NR-1:0]   prev_stall;
        logic [8*NR-1:0] prev_data;
        logic [NR-1:0]   prev_last;
        logic [10:0]     e;
        logic [2:0]      eg;
        prev_grant = '0;
        prev_stall = '0;
        prev_data  = '0;
        prev_last  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_grant = '0;
                prev_stall = '0;
                continue;
            end
            if (tx_valid && tx_ready) begin
                hs_count++;
                hs_cyc_q.push_back(cyc);
                $display("TX cyc=%0d grant=%b data=%02h", cyc, grant, tx_data);
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got grant %b byte %02h, expected nothing", grant, tx_data);
                end else begin
                    e = exp_tx_q.pop_front();
                    check("tx_byte", 32'({grant, tx_data}), 32'(e));
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: got %b expected none", grant);
                end else begin
                    eg = exp_grant_q.pop_front();
                    check("grant_seq", 32'(grant), 32'(eg));
                end
            end
            if (timeout_evt) to_count++;
            check("busy_vs_grant", 32'(busy), 32'(|grant));
            check("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
            for (int i = 0; i < NR; i++) begin
                if (prev_stall[i]) begin
                    check("req_hold", 32'({req_last[i], req_data[8*i +: 8]}),
                          32'({prev_last[i], prev_data[8*i +: 8]}));
                end
            end
            prev_stall = req_valid & ~req_ready;
            prev_data  = req_data;
            prev_last  = req_last;
            prev_grant = grant;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"},    32'(tx_valid),    32'd0);
        check({tag, "_tx_data"},     32'(tx_data),     32'd0);
        check({tag, "_grant"},       32'(grant),       32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_timeout_evt"}, 32'(timeout_evt), 32'd0);
        check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) head[i] = tail[i];
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
        exp_tx_q.delete();
        exp_grant_q.delete();
        hs_cyc_q.delete();
        tx_ready = 1'b1;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_tx_q.size() == 0 && exp_grant_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_complete"}, 32'(ok), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : main
        int c0;
        int c1;
        int c2;
        int h0;
        int t0;
        bit seen;

        rst       = 1'b1;
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        #2;
        check_reset_outputs("init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // T1: single requester, 3-byte packet, latency and drain timing.
        hs_cyc_q.delete();
        c0 = cyc;
        expect_grant(3'b001);
        expect_tx(3'b001, 8'h4D);
        expect_tx(3'b001, 8'h65);
        expect_tx(3'b001, 8'h0A);
        push(0, 8'h4D, 1'b0);
        push(0, 8'h65, 1'b0);
        push(0, 8'h0A, 1'b1);
        while (cyc < c0 + 5) @(negedge clk);
        check("t1_busy_in_drain", 32'(busy), 32'd1);
        check("t1_grant_in_drain", 32'(grant), 32'b001);
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_grant_clear", 32'(grant), 32'd0);
        wait_done("t1");
        check("t1_hs_count", 32'(hs_cyc_q.size()), 32'd3);
        if (hs_cyc_q.size() == 3) begin
            check("t1_first_latency", 32'(hs_cyc_q[0] - c0), 32'd3);
            check("t1_second_byte",   32'(hs_cyc_q[1] - c0), 32'd4);
            check("t1_third_byte",    32'(hs_cyc_q[2] - c0), 32'd5);
        end

        // T1b: pointer moved to 1, so req1 beats req0.
        expect_grant(3'b010);
        expect_grant(3'b001);
        expect_tx(3'b010, 8'h71);
        expect_tx(3'b001, 8'h70);
        push(0, 8'h70, 1'b1);
        push(1, 8'h71, 1'b1);
        wait_done("t1_ptr");

        // T2: two packets, no interleave, one idle cycle between them.
        do_reset("t2_rst");
        expect_grant(3'b001);
        expect_grant(3'b100);
        expect_tx(3'b001, 8'h11);
        expect_tx(3'b001, 8'h12);
        expect_tx(3'b100, 8'h21);
        expect_tx(3'b100, 8'h22);
        push(0, 8'h11, 1'b0);
        push(0, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        wait_done("t2");
        check("t2_hs_count", 32'(hs_cyc_q.size()), 32'd4);
        if (hs_cyc_q.size() == 4) begin
            check("t2_pkt0_b2b", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd1);
            check("t2_idle_gap", 32'(hs_cyc_q[2] - hs_cyc_q[1]), 32'd3);
            check("t2_pkt1_b2b", 32'(hs_cyc_q[3] - hs_cyc_q[2]), 32'd1);
        end

        // T3: all three offer two 1-byte packets each; fair rotation.
        do_reset("t3_rst");
        expect_grant(3'b001);
        expect_grant(3'b010);
        expect_grant(3'b100);
        expect_grant(3'b001);
        expect_grant(3'b010);
        expect_grant(3'b100);
        expect_tx(3'b001, 8'hA0);
        expect_tx(3'b010, 8'hB0);
        expect_tx(3'b100, 8'hC0);
        expect_tx(3'b001, 8'hA1);
        expect_tx(3'b010, 8'hB1);
        expect_tx(3'b100, 8'hC1);
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b1);
        push(1, 8'hB1, 1'b1);
        push(2, 8'hC0, 1'b1);
        push(2, 8'hC1, 1'b1);
        wait_done("t3");

        // T4: 50-cycle back-pressure stall with the owner still valid.
        do_reset("t4_rst");
        t0 = to_count;
        h0 = hs_count;
        expect_grant(3'b001);
        expect_tx(3'b001, 8'hD1);
        expect_tx(3'b001, 8'hD2);
        expect_tx(3'b001, 8'hD3);
        push(0, 8'hD1, 1'b0);
        push(0, 8'hD2, 1'b0);
        push(0, 8'hD3, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (hs_count > h0) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_first_byte_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            check("t4_stall_valid", 32'(tx_valid), 32'd1);
            check("t4_stall_data", 32'(tx_data), 32'hD2);
            check("t4_no_timeout", 32'(timeout_evt), 32'd0);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_done("t4");
        check("t4_timeout_count", 32'(to_count - t0), 32'd0);

        // T5: owner goes quiet mid-packet; watchdog revokes after 16 cycles.
        do_reset("t5_rst");
        t0 = to_count;
        expect_grant(3'b010);
        expect_grant(3'b100);
        expect_tx(3'b010, 8'h31);
        expect_tx(3'b100, 8'h41);
        push(1, 8'h31, 1'b0);
        push(2, 8'h41, 1'b1);
        c1 = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (grant == 3'b010 && !req_valid[1]) begin
                c1 = cyc;
                break;
            end
        end
        check("t5_owner_quiet_seen", 32'(c1 >= 0), 32'd1);
        c2 = -1;
        for (int n = 0; n < 100; n++) begin
            if (timeout_evt) begin
                c2 = cyc;
                break;
            end
            @(negedge clk);
        end
        check("t5_timeout_seen", 32'(c2 >= 0), 32'd1);
        check("t5_timeout_delay", 32'(c2 - c1), 32'd16);
        @(negedge clk);
        check("t5_pulse_width", 32'(timeout_evt), 32'd0);
        wait_done("t5");
        check("t5_timeout_count", 32'(to_count - t0), 32'd1);

        // T6: reset mid-packet, then a normal 1-byte packet.
        do_reset("t6_pre");
        h0 = hs_count;
        expect_grant(3'b001);
        expect_tx(3'b001, 8'h61);
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b0);
        push(0, 8'h63, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (hs_count > h0) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_first_byte_seen", 32'(seen), 32'd1);
        do_reset("t6_mid");
        expect_grant(3'b001);
        expect_tx(3'b001, 8'h55);
        push(0, 8'h55, 1'b1);
        wait_done("t6");
        check("total_timeouts", 32'(to_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
